// File: rtl/exec_monitor.sv
// Run monitor for the CPU commit stream. It detects the halt self-loop, enforces a
// cycle budget, and records retire/cycle counts and register write-back activity.
module exec_monitor #(
  parameter int                XLEN           = 32,
  parameter logic [XLEN-1:0]   HALT_PC        = XLEN'(32'h00000020),
  parameter logic [31:0]       HALT_INST      = 32'h00008067,
  parameter int                DRAIN_CYCLES   = 3,
  parameter int                TIMEOUT_CYCLES = 50
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     inst,
  input  logic            reg_wen,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            halted,
  output logic            timed_out,
  output logic [31:0]     retire_cnt,
  output logic [31:0]     cycle_cnt,
  output logic [4:0]      last_rd,
  output logic [XLEN-1:0] last_wb_data,
  output logic [31:0]     wr_mask,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DRAIN   = 3'd2,
    S_HALTED  = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam logic [31:0] DRAIN_LOAD   = 32'(DRAIN_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] drain_q, drain_d;
  logic        halt_match;
  logic        timeout_hit;
  logic        run_edge;
  logic        track_edge;

  assign halt_match  = (pc == HALT_PC) && (inst == HALT_INST);
  // Only RUN cycles have elapsed before DRAIN, so cycle_cnt doubles as the RUN budget count.
  assign timeout_hit = (cycle_cnt == TIMEOUT_LAST);

  // The IDLE edge that sees en=1 is already the first sampled RUN cycle.
  assign run_edge   = en && ((state_q == S_IDLE) || (state_q == S_RUN));
  assign track_edge = run_edge || (en && (state_q == S_DRAIN));

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign halted    = (state_q == S_HALTED);
  assign timed_out = (state_q == S_TIMEOUT);
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      drain_q <= 32'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (en) begin
          // Halt wins over a timeout landing on the same edge.
          if (halt_match) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_LOAD;
          end else if (timeout_hit) begin
            state_d = S_TIMEOUT;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        if (en) begin
          if (drain_q == 32'd0) state_d = S_HALTED;
          else                  drain_d = drain_q - 32'd1;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt   <= 32'd0;
      cycle_cnt    <= 32'd0;
      last_rd      <= 5'd0;
      last_wb_data <= '0;
      wr_mask      <= 32'd0;
    end else begin
      if (run_edge) retire_cnt <= retire_cnt + 32'd1;
      if (track_edge && (cycle_cnt != 32'hFFFF_FFFF)) cycle_cnt <= cycle_cnt + 32'd1;
      if (track_edge && reg_wen && (rd != 5'd0)) begin
        wr_mask[rd]  <= 1'b1;
        last_rd      <= rd;
        last_wb_data <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_exec_monitor.sv
// Directed bench for exec_monitor: reset, halt/drain, timeout, tie, write tracking, pause.
module tb_exec_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        reg_wen;
  logic [4:0]  rd;
  logic [31:0] wb_data;
  logic        busy, halted, timed_out;
  logic [31:0] retire_cnt, cycle_cnt, last_wb_data, wr_mask;
  logic [4:0]  last_rd;
  logic [2:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] HPC   = 32'h0000_0020;
  localparam logic [31:0] HINST = 32'h0000_8067;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  exec_monitor dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pc(pc), .inst(inst),
    .reg_wen(reg_wen), .rd(rd), .wb_data(wb_data),
    .busy(busy), .halted(halted), .timed_out(timed_out),
    .retire_cnt(retire_cnt), .cycle_cnt(cycle_cnt),
    .last_rd(last_rd), .last_wb_data(last_wb_data), .wr_mask(wr_mask),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [31:0] p, input logic [31:0] i,
                       input logic w, input logic [4:0] r, input logic [31:0] d);
    en = e; pc = p; inst = i; reg_wen = w; rd = r; wb_data = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, NOP, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, NOP, 1'b0, 5'd0, 32'h0);

    // Reset state, and IDLE with en=0 stays quiet.
    do_reset();
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_timed_out", 32'(timed_out), 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_wr_mask", wr_mask, 32'd0);

    // Halt after 8 distinct pcs, then a 3-cycle drain.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), NOP, 1'b0, 5'd0, 32'h0);
      step();
    end
    chk("t2_busy_run", 32'(busy), 32'd1);
    chk("t2_retire8", retire_cnt, 32'd8);
    drive(1'b1, HPC, HINST, 1'b0, 5'd0, 32'h0);
    step();
    chk("t2_busy_drain", 32'(busy), 32'd1);
    chk("t2_retire9", retire_cnt, 32'd9);
    chk("t2_cycle9", cycle_cnt, 32'd9);
    step();
    step();
    chk("t2_not_yet_halted", 32'(halted), 32'd0);
    chk("t2_retire_drain", retire_cnt, 32'd9);
    step();
    chk("t2_halted", 32'(halted), 32'd1);
    chk("t2_busy_done", 32'(busy), 32'd0);
    chk("t2_cycle12", cycle_cnt, 32'd12);
    drive(1'b1, HPC, HINST, 1'b1, 5'd3, 32'hDEAD_BEEF);
    step();
    step();
    chk("t2_sticky_halted", 32'(halted), 32'd1);
    chk("t2_cycle_frozen", cycle_cnt, 32'd12);
    chk("t2_retire_frozen", retire_cnt, 32'd9);
    chk("t2_no_post_write", wr_mask, 32'd0);

    // Asynchronous reset mid-RUN clears everything before the next edge.
    do_reset();
    drive(1'b1, 32'h40, NOP, 1'b1, 5'd7, 32'h7777_0000);
    step();
    step();
    chk("t1_pre_mask", wr_mask, 32'h0000_0080);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_retire", retire_cnt, 32'd0);
    chk("t1_cycle", cycle_cnt, 32'd0);
    chk("t1_mask", wr_mask, 32'd0);
    chk("t1_last_rd", 32'(last_rd), 32'd0);
    chk("t1_last_wb", last_wb_data, 32'd0);
    step();
    rst_n = 1'b1;

    // Timeout: pc never reaches the halt address.
    do_reset();
    drive(1'b1, 32'h40, NOP, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 49; k++) step();
    chk("t3_not_timed_49", 32'(timed_out), 32'd0);
    chk("t3_cycle49", cycle_cnt, 32'd49);
    step();
    chk("t3_timed_out", 32'(timed_out), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_cycle50", cycle_cnt, 32'd50);
    chk("t3_retire50", retire_cnt, 32'd50);
    step();
    step();
    chk("t3_halted_low", 32'(halted), 32'd0);
    chk("t3_cycle_frozen", cycle_cnt, 32'd50);

    // Halt on the same edge as the budget expires: halt wins.
    do_reset();
    drive(1'b1, 32'h40, NOP, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 49; k++) step();
    drive(1'b1, HPC, HINST, 1'b0, 5'd0, 32'h0);
    step();
    chk("t4_busy_drain", 32'(busy), 32'd1);
    chk("t4_timed_low", 32'(timed_out), 32'd0);
    chk("t4_retire50", retire_cnt, 32'd50);
    step();
    step();
    step();
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_timed_low_end", 32'(timed_out), 32'd0);
    chk("t4_cycle53", cycle_cnt, 32'd53);

    // Write tracking; x0 writes are ignored.
    do_reset();
    drive(1'b1, 32'h40, NOP, 1'b1, 5'd5, 32'hAAAA_A555);
    step();
    drive(1'b1, 32'h44, NOP, 1'b1, 5'd0, 32'h0000_1234);
    step();
    chk("t5_mask", wr_mask, 32'h0000_0020);
    chk("t5_last_rd", 32'(last_rd), 32'd5);
    chk("t5_last_wb", last_wb_data, 32'hAAAA_A555);

    // Pause: en=0 holds counters and tracking, then counting resumes.
    drive(1'b0, 32'h48, NOP, 1'b1, 5'd6, 32'h0000_0066);
    for (int k = 0; k < 4; k++) step();
    chk("t6_busy_paused", 32'(busy), 32'd1);
    chk("t6_cycle_held", cycle_cnt, 32'd2);
    chk("t6_retire_held", retire_cnt, 32'd2);
    chk("t6_mask_held", wr_mask, 32'h0000_0020);
    chk("t6_last_rd_held", 32'(last_rd), 32'd5);
    en = 1'b1;
    step();
    chk("t6_cycle_resume", cycle_cnt, 32'd3);
    chk("t6_retire_resume", retire_cnt, 32'd3);
    chk("t6_mask_resume", wr_mask, 32'h0000_0060);
    chk("t6_last_rd_resume", 32'(last_rd), 32'd6);
    chk("t6_last_wb_resume", last_wb_data, 32'h0000_0066);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
